operator_alu_scheduler: RTL and testbench

//  Shares one multi-function operator ALU between NUM_REQ requesters.

---
 rtl/operator_pkg.sv | 28 ++
 rtl/operator_alu.sv | 56 +++++
 rtl/operator_alu_scheduler.sv | 152 +++++++++++++++
 tb/tb_operator_alu_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operator_pkg.sv
// Shared definitions for the operator examples: ALU opcode encodings and the
// scheduler FSM state type.
package operator_pkg;

    localparam logic [3:0] OPC_ADD  = 4'h0;
    localparam logic [3:0] OPC_SUB  = 4'h1;
    localparam logic [3:0] OPC_LAND = 4'h2;
    localparam logic [3:0] OPC_LOR  = 4'h3;
    localparam logic [3:0] OPC_LT   = 4'h4;
    localparam logic [3:0] OPC_EQ   = 4'h5;
    localparam logic [3:0] OPC_AND  = 4'h6;
    localparam logic [3:0] OPC_OR   = 4'h7;
    localparam logic [3:0] OPC_XOR  = 4'h8;
    localparam logic [3:0] OPC_RAND = 4'h9;
    localparam logic [3:0] OPC_RXOR = 4'hA;
    localparam logic [3:0] OPC_SHL  = 4'hB;
    localparam logic [3:0] OPC_SHR  = 4'hC;
    localparam logic [3:0] OPC_CAT  = 4'hD;
    localparam logic [3:0] OPC_COND = 4'hE;
    localparam logic [3:0] OPC_RSVD = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/operator_alu.sv
// Purely combinational multi-function operator ALU. One-bit results sit in
// bit 0 and are zero-extended; the flag carries ADD carry, SUB borrow, or
// marks the reserved opcode.
module operator_alu #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [3:0]            i_opcode,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_flag
);
    import operator_pkg::*;

    localparam int HALF = DATA_WIDTH / 2;
    localparam logic [DATA_WIDTH-1:0] SHIFT_LIMIT = DATA_WIDTH'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-2:0] HI_ZERO = '0;

    logic [DATA_WIDTH:0] w_sum;

    assign w_sum = {1'b0, i_a} + {1'b0, i_b};

    // Decode the opcode and produce the result and flag for that operator.
    always_comb begin
        o_result = '0;
        o_flag   = 1'b0;
        case (i_opcode)
            OPC_ADD: begin
                o_result = w_sum[DATA_WIDTH-1:0];
                o_flag   = w_sum[DATA_WIDTH];
            end
            OPC_SUB: begin
                o_result = i_a - i_b;
                o_flag   = (i_a < i_b);
            end
            OPC_LAND: o_result = {HI_ZERO, ((|i_a) && (|i_b))};
            OPC_LOR:  o_result = {HI_ZERO, ((|i_a) || (|i_b))};
            OPC_LT:   o_result = {HI_ZERO, (i_a < i_b)};
            OPC_EQ:   o_result = {HI_ZERO, (i_a == i_b)};
            OPC_AND:  o_result = i_a & i_b;
            OPC_OR:   o_result = i_a | i_b;
            OPC_XOR:  o_result = i_a ^ i_b;
            OPC_RAND: o_result = {HI_ZERO, (&i_a)};
            OPC_RXOR: o_result = {HI_ZERO, (^i_a)};
            OPC_SHL:  o_result = (i_b >= SHIFT_LIMIT) ? '0 : (i_a << i_b);
            OPC_SHR:  o_result = (i_b >= SHIFT_LIMIT) ? '0 : (i_a >> i_b);
            OPC_CAT:  o_result = {i_a[HALF-1:0], i_b[HALF-1:0]};
            OPC_COND: o_result = (|i_a) ? i_b : ~i_b;
            default: begin
                o_result = '0;
                o_flag   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/operator_alu_scheduler.sv
// Shares one operator ALU between NUM_REQ requesters. A round-robin arbiter
// grants one request at a time from IDLE, the operands are latched, the ALU
// result is registered in EXEC and held in RESP until the consumer accepts.
module operator_alu_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*4-1:0]          req_opcode,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_operand_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_result,
    output logic                          rsp_flag,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic                          busy
);
    import operator_pkg::*;

    localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [3:0]            r_opcode;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [ID_WIDTH-1:0]   r_id;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_flag;
    logic [ID_WIDTH-1:0]   r_rsp_id;
    logic                  r_busy;

    logic [3:0]            w_opc_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_a_arr   [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_b_arr   [NUM_REQ];

    logic                  w_grant_found;
    logic [ID_WIDTH-1:0]   w_grant_idx;
    logic [ID_WIDTH:0]     w_scan_sum;
    logic [ID_WIDTH-1:0]   w_scan_idx;
    logic                  w_grant;
    logic [DATA_WIDTH-1:0] w_alu_result;
    logic                  w_alu_flag;

    genvar gi;
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_opc_arr[gi] = req_opcode[4*gi +: 4];
        assign w_a_arr[gi]   = req_operand_a[DATA_WIDTH*gi +: DATA_WIDTH];
        assign w_b_arr[gi]   = req_operand_b[DATA_WIDTH*gi +: DATA_WIDTH];
    end

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan_sum    = '0;
        w_scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_sum = {1'b0, r_rr_ptr} + (ID_WIDTH+1)'(k);
            if (w_scan_sum >= NUM_REQ_W) begin
                w_scan_sum = w_scan_sum - NUM_REQ_W;
            end
            w_scan_idx = w_scan_sum[ID_WIDTH-1:0];
            if (!w_grant_found && req_valid[w_scan_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_scan_idx;
            end
        end
    end

    assign w_grant = rst_n && (r_state == S_IDLE) && w_grant_found;

    // One-hot ready to the granted requester, only in the cycle the grant is made.
    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    operator_alu #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .i_opcode (r_opcode),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_flag   (w_alu_flag)
    );

    // Scheduler FSM: grant and latch in IDLE, register the ALU output in EXEC, hold in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_opcode    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_result    <= '0;
            r_flag      <= 1'b0;
            r_rsp_id    <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_opcode <= w_opc_arr[w_grant_idx];
                        r_a      <= w_a_arr[w_grant_idx];
                        r_b      <= w_b_arr[w_grant_idx];
                        r_id     <= w_grant_idx;
                        r_busy   <= 1'b1;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result    <= w_alu_result;
                    r_flag      <= w_alu_flag;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_rr_ptr    <= (r_rsp_id == LAST_ID) ? '0 : (r_rsp_id + ID_WIDTH'(1));
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_flag   = r_flag;
    assign rsp_id     = r_rsp_id;
    assign busy       = r_busy;

endmodule

// File: tb/tb_operator_alu_scheduler.sv
// Self-checking bench for operator_alu_scheduler: a transaction-level model
// checked every cycle, directed literal cases, and randomized traffic.
module tb_operator_alu_scheduler;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*4-1:0]   req_opcode;
    logic [NR*DW-1:0]  req_operand_a;
    logic [NR*DW-1:0]  req_operand_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_result;
    logic              rsp_flag;
    logic [IW-1:0]     rsp_id;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bit m_busy = 1'b0;
    int m_ptr = 0;
    int m_grant_cyc = 0;
    int m_res = 0;
    int m_flag = 0;
    int m_id = 0;

    int c_g;
    int c_idx;
    int c_exp_ready;
    bit c_exp_rv;

    logic [NR-1:0] hs;

    operator_alu_scheduler #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .ID_WIDTH(IW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_opcode    (req_opcode),
        .req_operand_a (req_operand_a),
        .req_operand_b (req_operand_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flag      (rsp_flag),
        .rsp_id        (rsp_id),
        .busy          (busy)
    );

    // Free-running clock and cycle counter.
    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Safety net so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Operator semantics written directly from the opcode table with integer arithmetic.
    function automatic void aluModel(input int opc, input int a, input int b, output int r, output int f);
        int s;
        r = 0;
        f = 0;
        case (opc)
            0:  begin s = a + b; r = s % 256; f = (s > 255) ? 1 : 0; end
            1:  begin r = (a - b + 256) % 256; f = (a < b) ? 1 : 0; end
            2:  r = (a != 0 && b != 0) ? 1 : 0;
            3:  r = (a != 0 || b != 0) ? 1 : 0;
            4:  r = (a < b) ? 1 : 0;
            5:  r = (a == b) ? 1 : 0;
            6:  r = a & b;
            7:  r = a | b;
            8:  r = a ^ b;
            9:  r = (a == 255) ? 1 : 0;
            10: r = $countones(a) % 2;
            11: r = (b >= 8) ? 0 : (a * (2 ** b)) % 256;
            12: r = (b >= 8) ? 0 : a / (2 ** b);
            13: r = (a % 16) * 16 + (b % 16);
            14: r = (a != 0) ? b : 255 - b;
            default: begin r = 0; f = 1; end
        endcase
    endfunction

    // Per-cycle compare of every output against the transaction-level model.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            checkOutput("rst_req_ready", req_ready, 0);
            checkOutput("rst_rsp_valid", rsp_valid, 0);
            checkOutput("rst_busy", busy, 0);
        end else begin
            c_g = -1;
            if (!m_busy) begin
                for (int k = 0; k < NR; k++) begin
                    c_idx = (m_ptr + k) % NR;
                    if (c_g < 0 && req_valid[c_idx]) c_g = c_idx;
                end
            end
            c_exp_ready = (c_g >= 0) ? (1 << c_g) : 0;
            c_exp_rv = m_busy && ((cyc - m_grant_cyc) >= 2);
            checkOutput("model_req_ready", req_ready, c_exp_ready);
            checkOutput("model_busy", busy, m_busy);
            checkOutput("model_rsp_valid", rsp_valid, c_exp_rv);
            if (c_exp_rv) begin
                checkOutput("model_result", rsp_result, m_res);
                checkOutput("model_flag", rsp_flag, m_flag);
                checkOutput("model_id", rsp_id, m_id);
            end
            if (c_g >= 0) begin
                m_busy = 1'b1;
                m_grant_cyc = cyc;
                m_id = c_g;
                aluModel(int'(req_opcode[4*c_g +: 4]), int'(req_operand_a[DW*c_g +: DW]),
                         int'(req_operand_b[DW*c_g +: DW]), m_res, m_flag);
            end else if (c_exp_rv && rsp_ready) begin
                m_busy = 1'b0;
                m_ptr = (m_id + 1) % NR;
            end
        end
    end

    task automatic doReset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic setSlot(input int idx, input int opc, input int a, input int b);
        req_opcode[4*idx +: 4]     = 4'(opc);
        req_operand_a[DW*idx +: DW] = 8'(a);
        req_operand_b[DW*idx +: DW] = 8'(b);
    endtask

    // Single request from one requester, with literal result and latency checks.
    task automatic applyStimulus(input int idx, input int opc, input int a, input int b,
                                 input int expRes, input int expFlag);
        bit got;
        int lat;
        @(posedge clk);
        #1;
        setSlot(idx, opc, a, b);
        req_valid[idx] = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            #1;
            if (req_ready[idx]) got = 1'b1;
        end
        checkOutput("dir_grant", got, 1);
        @(posedge clk);
        #1 req_valid[idx] = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) lat = n;
        end
        checkOutput("dir_latency", lat, 2);
        checkOutput("dir_result", rsp_result, expRes);
        checkOutput("dir_flag", rsp_flag, expFlag);
        checkOutput("dir_id", rsp_id, idx);
    endtask

    // Randomized requesters that hold valid and payload until served.
    task automatic runRandom(input int cycles);
        hs = '0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && !hs[i]) begin
                    if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = ($urandom_range(2) != 0);
                    setSlot(i, int'($urandom_range(15)), int'($urandom_range(255)),
                            ($urandom_range(1) == 0) ? int'($urandom_range(10)) : int'($urandom_range(255)));
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            #1 hs = req_valid & req_ready;
        end
    endtask

    int gid [5];
    int gcyc [5];
    int ng;
    bit seen;

    initial begin
        req_valid = '0;
        req_opcode = '0;
        req_operand_a = '0;
        req_operand_b = '0;
        rsp_ready = 1'b1;

        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_req_ready", req_ready, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_result", rsp_result, 0);
        checkOutput("reset_rsp_flag", rsp_flag, 0);
        checkOutput("reset_rsp_id", rsp_id, 0);
        checkOutput("reset_busy", busy, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        $display("[TB] directed operator cases");
        applyStimulus(0, 4'h0, 8'hF0, 8'h20, 8'h10, 1);
        applyStimulus(1, 4'hB, 8'hA5, 8'h03, 8'h28, 0);
        applyStimulus(2, 4'hC, 8'hA5, 8'h03, 8'h14, 0);
        applyStimulus(3, 4'hD, 8'hA5, 8'h03, 8'h53, 0);
        applyStimulus(0, 4'hA, 8'hA5, 8'h03, 8'h00, 0);
        applyStimulus(1, 4'h9, 8'hA5, 8'h03, 8'h00, 0);
        applyStimulus(2, 4'h4, 8'hA5, 8'h03, 8'h00, 0);
        applyStimulus(3, 4'h1, 8'hA5, 8'h03, 8'hA2, 0);
        applyStimulus(0, 4'hB, 8'hA5, 8'h08, 8'h00, 0);
        applyStimulus(1, 4'hF, 8'h12, 8'h34, 8'h00, 1);
        applyStimulus(2, 4'hE, 8'h00, 8'h0F, 8'hF0, 0);
        applyStimulus(3, 4'h5, 8'h5A, 8'h5A, 8'h01, 0);
        applyStimulus(0, 4'h1, 8'h03, 8'h05, 8'hFE, 1);
        applyStimulus(1, 4'h0, 8'hFF, 8'h01, 8'h00, 1);
        applyStimulus(2, 4'h2, 8'h00, 8'hFF, 8'h00, 0);

        $display("[TB] round-robin with all requesters active");
        doReset();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) setSlot(i, 0, i, 1);
        req_valid = '1;
        rsp_ready = 1'b1;
        ng = 0;
        for (int n = 0; n < 40 && ng < 5; n++) begin
            @(negedge clk);
            #1;
            if (req_ready != '0) begin
                checkOutput("rr_onehot", $onehot(req_ready), 1);
                for (int i = 0; i < NR; i++) if (req_ready[i]) gid[ng] = i;
                gcyc[ng] = cyc;
                ng++;
            end
        end
        checkOutput("rr_count", ng, 5);
        for (int i = 0; i < 5; i++) begin
            if (i < ng) begin
                checkOutput("rr_order", gid[i], i % NR);
                if (i > 0) checkOutput("rr_spacing", gcyc[i] - gcyc[i-1], 3);
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);

        $display("[TB] response backpressure");
        #1;
        rsp_ready = 1'b0;
        setSlot(1, 4'h8, 8'h3C, 8'h0F);
        req_valid[1] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (req_ready[1]) seen = 1'b1;
        end
        checkOutput("bp_grant", seen, 1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        setSlot(0, 0, 8'h11, 8'h22);
        setSlot(2, 6, 8'hF0, 8'h3C);
        setSlot(3, 7, 8'h0F, 8'h30);
        req_valid[0] = 1'b1;
        req_valid[2] = 1'b1;
        req_valid[3] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        checkOutput("bp_rsp_seen", seen, 1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            checkOutput("bp_rsp_valid", rsp_valid, 1);
            checkOutput("bp_result", rsp_result, 8'h33);
            checkOutput("bp_id", rsp_id, 1);
            checkOutput("bp_req_ready", req_ready, 0);
            checkOutput("bp_busy", busy, 1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1 req_valid = '0;
        repeat (6) @(posedge clk);

        $display("[TB] reset during execution");
        #1;
        setSlot(2, 0, 8'h11, 8'h22);
        req_valid[2] = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (req_ready[2]) seen = 1'b1;
        end
        checkOutput("rx_grant", seen, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("rx_req_ready", req_ready, 0);
        checkOutput("rx_rsp_valid", rsp_valid, 0);
        checkOutput("rx_rsp_result", rsp_result, 0);
        checkOutput("rx_rsp_flag", rsp_flag, 0);
        checkOutput("rx_rsp_id", rsp_id, 0);
        checkOutput("rx_busy", busy, 0);
        req_valid[2] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1 checkOutput("rx_no_rsp", rsp_valid, 0);
        end

        $display("[TB] randomized traffic");
        runRandom(800);
        @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("drain_busy", busy, 0);
        checkOutput("drain_rsp_valid", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
